mem_stage_top: RTL and testbench
================================

# mem_stage_top

Memory pipeline stage of the RV32I core. It takes the EX/MEM pipeline register contents and issues load/store requests to the data memory over a req/ack handshake, stalling the pipeline for wait-state memory. It aligns and extends load data and registers the MEM/WB pipeline register that directly feeds the write-back stage.

## Interface
- BITS, 32 (common_params constant, not overridden): datapath width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- EX_MEM_VALID  in  1  instruction in EX/MEM is valid
- EX_MEM_EXECUTE_OUT  in  BITS  ALU result; byte address for loads/stores
- EX_MEM_STORE_DATA  in  BITS  rs2 value for stores
- EX_MEM_MEM_RD, EX_MEM_MEM_WR  in  1 each  load / store (never both)
- EX_MEM_MEM_SIZE  in  mem_size_t  BYTE_size, HALF_size, WORD_size
- EX_MEM_MEM_UNSIGNED  in  1  LBU/LHU zero-extend
- EX_MEM_WB_SRC_SEL  in  wb_mux_t  forwarded to MEM/WB
- EX_MEM_RD  in  5  destination register; EX_MEM_REG_WR  in  1  write enable
- DMEM_REQ  out  1  access request; DMEM_WE  out  1  store
- DMEM_ADDR  out  BITS  word-aligned address ({addr[31:2],2'b00})
- DMEM_BE  out  4  byte enables; DMEM_WDATA  out  BITS  lane-replicated store data
- DMEM_RDATA  in  BITS  read word, valid when DMEM_ACK=1; DMEM_ACK  in  1  access complete
- MEM_STALL  out  1  freeze IF/ID/EX and EX/MEM
- MEM_WB_VALID, MEM_WB_REG_WR  out  1 each; MEM_WB_RD  out  5
- MEM_WB_WB_SRC_SEL  out  wb_mux_t; MEM_WB_MEM_DATA_OUT, MEM_WB_EXECUTE_OUT  out  BITS
- MEM_WB_MISALIGN  out  1  registered misaligned-access flag

## Operation
- ACCESS = EX_MEM_VALID & (MEM_RD | MEM_WR) & aligned. Aligned: BYTE always; HALF addr[0]=0; WORD addr[1:0]=0.
- FSM mem_state_t {IDLE, WAIT}. IDLE: DMEM_REQ = ACCESS. ACCESS & DMEM_ACK -> complete, stay IDLE. ACCESS & !DMEM_ACK -> WAIT. WAIT: DMEM_REQ=1; DMEM_ACK -> complete, IDLE; else stay.
- MEM_STALL = DMEM_REQ & !DMEM_ACK (combinational). Upstream holds EX/MEM stable while stalled, so request fields stay constant.
- Store: BYTE BE = 1<<addr[1:0], WDATA = {4{data[7:0]}}; HALF BE = addr[1]?1100:0011, WDATA = {2{data[15:0]}}; WORD BE=1111. Loads drive BE=1111, WE=0.
- Load: BYTE selects lane addr[1:0], HALF selects addr[1]; sign-extend unless MEM_UNSIGNED; WORD passes through.
- Misaligned load/store: no request, no stall; MEM/WB captures the instruction with REG_WR forced 0 and MISALIGN=1.
- Non-memory instruction: passes to MEM/WB in one cycle, MEM_DATA_OUT=0.
- While MEM_STALL=1, MEM/WB loads a bubble: VALID=0, REG_WR=0, MISALIGN=0 (other fields don't-care, hold).
- DMEM_ACK while DMEM_REQ=0 is ignored.

## Timing
- Reset: state IDLE; all MEM_WB_* outputs 0 (WB_SRC_SEL encoding 0); DMEM_REQ=0 in the following cycle.
- Zero-wait memory (ACK same cycle as REQ): 1-cycle stage latency, no stall.
- N wait cycles: MEM_STALL high N cycles; MEM/WB updates on the ACK edge.
- Store data is committed on the ACK cycle only. Memory must not act on an unacknowledged request dropped by reset.
- Reset in WAIT: return to IDLE; a late ACK afterwards is ignored.
- MEM/WB updates every unstalled cycle. There is no separate enable.

## Structure
- common_params gains mem_size_t and mem_state_t. It reuses BITS, wb_mux_t and DATA_MEM_wbmux.
- Sub-module load_align: purely combinational. Inputs are RDATA, addr[1:0], size and unsigned; output is the extended word. It is instantiated once and unit-tested separately.
- Store lane/BE generation, the FSM and the MEM/WB register live in mem_stage_top.

## Test plan
- LW addr 0x100, RDATA 0xDEADBEEF, ACK same cycle -> no stall; next cycle MEM_WB_MEM_DATA_OUT=0xDEADBEEF, REG_WR=1.
- LB addr 0x103, RDATA 0x80FF_0000 -> 0xFFFFFF80. LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, data 0x12345678 -> BE=0010, WDATA=0x78787878, DMEM_ADDR=0x200. SH addr 0x202 -> BE=1100, WDATA=0x56785678.
- LW with ACK delayed 3 cycles -> MEM_STALL high exactly 3 cycles, 3 bubbles (VALID=0) in MEM/WB, then the loaded word.
- LW addr 0x102 -> no DMEM_REQ; MEM_WB_MISALIGN=1, REG_WR=0, VALID=1 for one cycle.
- rst asserted in WAIT, ACK arrives 1 cycle after reset -> all MEM_WB_* zero, state IDLE, no MEM/WB capture.

Source files
------------

// File: rtl/common_params.sv
`default_nettype none
// ============================================================================
// Module : common_params
// Brief  : Shared RV32I core types and constants (datapath width, WB mux,
//          memory access size, memory-stage FSM states).
// Rev    : 1.0
// ============================================================================
package common_params;

  localparam int BITS = 32;

  typedef enum logic [1:0] {
    ALU_wbmux      = 2'd0,
    DATA_MEM_wbmux = 2'd1,
    PC4_wbmux      = 2'd2,
    IMM_wbmux      = 2'd3
  } wb_mux_t;

  typedef enum logic [1:0] {
    BYTE_size = 2'd0,
    HALF_size = 2'd1,
    WORD_size = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Natural alignment: bytes anywhere, halves on even, words on 4-byte.
  function automatic logic is_aligned(input mem_size_t size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b1;
    case (size)
      HALF_size: ok = ~addr_lo[0];
      WORD_size: ok = (addr_lo == 2'b00);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_top_load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Selects the addressed byte/half lane of a read word and sign- or
//          zero-extends it to the full datapath width.
// Rev    : 1.0
// ============================================================================
module load_align
  import common_params::*;
(
  input  logic [BITS-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  mem_size_t       i_size,
  input  logic            i_unsigned,
  output logic [BITS-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_rdata;

    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      BYTE_size: o_data = {{(BITS-8){~i_unsigned & w_byte[7]}}, w_byte};
      HALF_size: o_data = {{(BITS-16){~i_unsigned & w_half[15]}}, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_top.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_top
// Brief  : RV32I memory stage: data-memory req/ack handshake with stall,
//          store lane generation, load alignment and the MEM/WB register.
// Rev    : 1.0
// ============================================================================
module mem_stage_top
  import common_params::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_MEM_VALID,
  input  logic [BITS-1:0] EX_MEM_EXECUTE_OUT,
  input  logic [BITS-1:0] EX_MEM_STORE_DATA,
  input  logic            EX_MEM_MEM_RD,
  input  logic            EX_MEM_MEM_WR,
  input  mem_size_t       EX_MEM_MEM_SIZE,
  input  logic            EX_MEM_MEM_UNSIGNED,
  input  wb_mux_t         EX_MEM_WB_SRC_SEL,
  input  logic [4:0]      EX_MEM_RD,
  input  logic            EX_MEM_REG_WR,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [BITS-1:0] DMEM_ADDR,
  output logic [3:0]      DMEM_BE,
  output logic [BITS-1:0] DMEM_WDATA,
  input  logic [BITS-1:0] DMEM_RDATA,
  input  logic            DMEM_ACK,
  output logic            MEM_STALL,
  output logic            MEM_WB_VALID,
  output logic            MEM_WB_REG_WR,
  output logic [4:0]      MEM_WB_RD,
  output wb_mux_t         MEM_WB_WB_SRC_SEL,
  output logic [BITS-1:0] MEM_WB_MEM_DATA_OUT,
  output logic [BITS-1:0] MEM_WB_EXECUTE_OUT,
  output logic            MEM_WB_MISALIGN
);

  mem_state_t      r_state;
  mem_state_t      w_state_next;
  logic            w_is_mem;
  logic            w_aligned;
  logic            w_access;
  logic            w_misalign;
  logic            w_req;
  logic            w_stall;
  logic [3:0]      w_be;
  logic [BITS-1:0] w_wdata;
  logic [BITS-1:0] w_load_data;

  logic            r_wb_valid;
  logic            r_wb_reg_wr;
  logic [4:0]      r_wb_rd;
  wb_mux_t         r_wb_sel;
  logic [BITS-1:0] r_wb_mem_data;
  logic [BITS-1:0] r_wb_exec;
  logic            r_wb_misalign;

  assign w_is_mem   = EX_MEM_VALID & (EX_MEM_MEM_RD | EX_MEM_MEM_WR);
  assign w_aligned  = is_aligned(EX_MEM_MEM_SIZE, EX_MEM_EXECUTE_OUT[1:0]);
  assign w_access   = w_is_mem & w_aligned;
  assign w_misalign = w_is_mem & ~w_aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        w_req = w_access;
        if (w_access && !DMEM_ACK) w_state_next = WAIT;
      end
      WAIT: begin
        w_req = 1'b1;
        if (DMEM_ACK) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Masking with rst keeps memory from completing a request that reset is abandoning.
  assign DMEM_REQ  = w_req & ~rst;
  assign w_stall   = DMEM_REQ & ~DMEM_ACK;
  assign MEM_STALL = w_stall;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = EX_MEM_STORE_DATA;
    if (EX_MEM_MEM_WR) begin
      case (EX_MEM_MEM_SIZE)
        BYTE_size: begin
          w_be    = 4'b0001 << EX_MEM_EXECUTE_OUT[1:0];
          w_wdata = {4{EX_MEM_STORE_DATA[7:0]}};
        end
        HALF_size: begin
          w_be    = EX_MEM_EXECUTE_OUT[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{EX_MEM_STORE_DATA[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = EX_MEM_STORE_DATA;
        end
      endcase
    end
  end

  assign DMEM_WE    = DMEM_REQ & EX_MEM_MEM_WR;
  assign DMEM_ADDR  = {EX_MEM_EXECUTE_OUT[BITS-1:2], 2'b00};
  assign DMEM_BE    = w_be;
  assign DMEM_WDATA = w_wdata;

  load_align u_load_align (
    .i_rdata    (DMEM_RDATA),
    .i_addr_lo  (EX_MEM_EXECUTE_OUT[1:0]),
    .i_size     (EX_MEM_MEM_SIZE),
    .i_unsigned (EX_MEM_MEM_UNSIGNED),
    .o_data     (w_load_data)
  );

  // A stalled cycle inserts a bubble; payload fields simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_reg_wr   <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_sel      <= ALU_wbmux;
      r_wb_mem_data <= '0;
      r_wb_exec     <= '0;
      r_wb_misalign <= 1'b0;
    end else if (w_stall) begin
      r_wb_valid    <= 1'b0;
      r_wb_reg_wr   <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else begin
      r_wb_valid    <= EX_MEM_VALID;
      r_wb_reg_wr   <= EX_MEM_VALID & EX_MEM_REG_WR & ~w_misalign;
      r_wb_rd       <= EX_MEM_RD;
      r_wb_sel      <= EX_MEM_WB_SRC_SEL;
      r_wb_mem_data <= (w_access & EX_MEM_MEM_RD) ? w_load_data : '0;
      r_wb_exec     <= EX_MEM_EXECUTE_OUT;
      r_wb_misalign <= w_misalign;
    end
  end

  assign MEM_WB_VALID        = r_wb_valid;
  assign MEM_WB_REG_WR       = r_wb_reg_wr;
  assign MEM_WB_RD           = r_wb_rd;
  assign MEM_WB_WB_SRC_SEL   = r_wb_sel;
  assign MEM_WB_MEM_DATA_OUT = r_wb_mem_data;
  assign MEM_WB_EXECUTE_OUT  = r_wb_exec;
  assign MEM_WB_MISALIGN     = r_wb_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_top.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage_top
// Brief  : Scoreboard bench for mem_stage_top with directed load/store vectors.
// Rev    : 1.0
// ============================================================================
module tb_mem_stage_top;
  import common_params::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MEM_VALID;
  logic [31:0] EX_MEM_EXECUTE_OUT;
  logic [31:0] EX_MEM_STORE_DATA;
  logic        EX_MEM_MEM_RD;
  logic        EX_MEM_MEM_WR;
  mem_size_t   EX_MEM_MEM_SIZE;
  logic        EX_MEM_MEM_UNSIGNED;
  wb_mux_t     EX_MEM_WB_SRC_SEL;
  logic [4:0]  EX_MEM_RD;
  logic        EX_MEM_REG_WR;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_WDATA;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        MEM_STALL;
  logic        MEM_WB_VALID;
  logic        MEM_WB_REG_WR;
  logic [4:0]  MEM_WB_RD;
  wb_mux_t     MEM_WB_WB_SRC_SEL;
  logic [31:0] MEM_WB_MEM_DATA_OUT;
  logic [31:0] MEM_WB_EXECUTE_OUT;
  logic        MEM_WB_MISALIGN;

  always #5 clk = ~clk;

  mem_stage_top dut (
    .clk                 (clk),
    .rst                 (rst),
    .EX_MEM_VALID        (EX_MEM_VALID),
    .EX_MEM_EXECUTE_OUT  (EX_MEM_EXECUTE_OUT),
    .EX_MEM_STORE_DATA   (EX_MEM_STORE_DATA),
    .EX_MEM_MEM_RD       (EX_MEM_MEM_RD),
    .EX_MEM_MEM_WR       (EX_MEM_MEM_WR),
    .EX_MEM_MEM_SIZE     (EX_MEM_MEM_SIZE),
    .EX_MEM_MEM_UNSIGNED (EX_MEM_MEM_UNSIGNED),
    .EX_MEM_WB_SRC_SEL   (EX_MEM_WB_SRC_SEL),
    .EX_MEM_RD           (EX_MEM_RD),
    .EX_MEM_REG_WR       (EX_MEM_REG_WR),
    .DMEM_REQ            (DMEM_REQ),
    .DMEM_WE             (DMEM_WE),
    .DMEM_ADDR           (DMEM_ADDR),
    .DMEM_BE             (DMEM_BE),
    .DMEM_WDATA          (DMEM_WDATA),
    .DMEM_RDATA          (DMEM_RDATA),
    .DMEM_ACK            (DMEM_ACK),
    .MEM_STALL           (MEM_STALL),
    .MEM_WB_VALID        (MEM_WB_VALID),
    .MEM_WB_REG_WR       (MEM_WB_REG_WR),
    .MEM_WB_RD           (MEM_WB_RD),
    .MEM_WB_WB_SRC_SEL   (MEM_WB_WB_SRC_SEL),
    .MEM_WB_MEM_DATA_OUT (MEM_WB_MEM_DATA_OUT),
    .MEM_WB_EXECUTE_OUT  (MEM_WB_EXECUTE_OUT),
    .MEM_WB_MISALIGN     (MEM_WB_MISALIGN)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        reg_wr;
    wb_mux_t     sel;
    logic [31:0] data;
    logic [31:0] exec;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every valid MEM/WB entry must match the oldest expectation.
  always @(negedge clk) begin
    if (MEM_WB_VALID === 1'b1) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got valid entry exec=0x%08h expected none", MEM_WB_EXECUTE_OUT);
      end else begin
        mon_e = sbq.pop_front();
        if (MEM_WB_RD !== mon_e.rd || MEM_WB_REG_WR !== mon_e.reg_wr ||
            MEM_WB_WB_SRC_SEL !== mon_e.sel || MEM_WB_MEM_DATA_OUT !== mon_e.data ||
            MEM_WB_EXECUTE_OUT !== mon_e.exec || MEM_WB_MISALIGN !== mon_e.mis) begin
          fails++;
          $display("FAIL wb_entry: got rd=%0d wr=%0b sel=%0d data=0x%08h exec=0x%08h mis=%0b expected rd=%0d wr=%0b sel=%0d data=0x%08h exec=0x%08h mis=%0b",
                   MEM_WB_RD, MEM_WB_REG_WR, MEM_WB_WB_SRC_SEL, MEM_WB_MEM_DATA_OUT,
                   MEM_WB_EXECUTE_OUT, MEM_WB_MISALIGN, mon_e.rd, mon_e.reg_wr, mon_e.sel,
                   mon_e.data, mon_e.exec, mon_e.mis);
        end
      end
    end
  end

  task automatic clear_ex();
    EX_MEM_VALID        = 1'b0;
    EX_MEM_EXECUTE_OUT  = 32'h0;
    EX_MEM_STORE_DATA   = 32'h0;
    EX_MEM_MEM_RD       = 1'b0;
    EX_MEM_MEM_WR       = 1'b0;
    EX_MEM_MEM_SIZE     = WORD_size;
    EX_MEM_MEM_UNSIGNED = 1'b0;
    EX_MEM_WB_SRC_SEL   = ALU_wbmux;
    EX_MEM_RD           = 5'd0;
    EX_MEM_REG_WR       = 1'b0;
    DMEM_ACK            = 1'b0;
  endtask

  task automatic run(input logic rdop, input logic wrop, input mem_size_t sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                     input int delay, input logic [4:0] rd, input logic regwr, input wb_mux_t sel,
                     input logic [31:0] exp_data, input logic exp_req, input logic [3:0] exp_be,
                     input logic [31:0] exp_wdata, input logic exp_mis);
    int stalls;
    @(negedge clk);
    EX_MEM_VALID        = 1'b1;
    EX_MEM_EXECUTE_OUT  = addr;
    EX_MEM_STORE_DATA   = sdata;
    EX_MEM_MEM_RD       = rdop;
    EX_MEM_MEM_WR       = wrop;
    EX_MEM_MEM_SIZE     = sz;
    EX_MEM_MEM_UNSIGNED = uns;
    EX_MEM_WB_SRC_SEL   = sel;
    EX_MEM_RD           = rd;
    EX_MEM_REG_WR       = regwr;
    DMEM_RDATA          = rdata;
    DMEM_ACK            = exp_req && (delay == 0);
    sbq.push_back('{rd, regwr & ~exp_mis, sel, exp_data, addr, exp_mis});
    #1;
    chk("dmem_req", {31'd0, DMEM_REQ}, {31'd0, exp_req});
    if (exp_req) begin
      chk("dmem_addr", DMEM_ADDR, {addr[31:2], 2'b00});
      chk("dmem_be", {28'd0, DMEM_BE}, {28'd0, exp_be});
      chk("dmem_we", {31'd0, DMEM_WE}, {31'd0, wrop});
      if (wrop) chk("dmem_wdata", DMEM_WDATA, exp_wdata);
    end
    chk("stall_now", {31'd0, MEM_STALL}, {31'd0, (exp_req && delay > 0)});
    stalls = 0;
    for (int i = 0; i < delay; i++) begin
      if (MEM_STALL) stalls++;
      @(negedge clk);
      chk("bubble_valid", {31'd0, MEM_WB_VALID}, 32'd0);
      DMEM_ACK = (i == delay - 1);
      #1;
    end
    if (delay > 0) begin
      chk("stall_cycles", stalls, delay);
      chk("stall_on_ack", {31'd0, MEM_STALL}, 32'd0);
    end
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, MEM_WB_VALID}, 32'd0);
    chk({tag, "_regwr"}, {31'd0, MEM_WB_REG_WR}, 32'd0);
    chk({tag, "_rd"}, {27'd0, MEM_WB_RD}, 32'd0);
    chk({tag, "_sel"}, {30'd0, MEM_WB_WB_SRC_SEL}, 32'd0);
    chk({tag, "_data"}, MEM_WB_MEM_DATA_OUT, 32'd0);
    chk({tag, "_exec"}, MEM_WB_EXECUTE_OUT, 32'd0);
    chk({tag, "_mis"}, {31'd0, MEM_WB_MISALIGN}, 32'd0);
    chk({tag, "_req"}, {31'd0, DMEM_REQ}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    DMEM_RDATA = 32'h0;
    clear_ex();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_wb_zero("reset");

    //  rd wr size      uns addr          sdata         rdata         dly rd     wr sel             exp_data      req be       wdata         mis
    run(1, 0, WORD_size, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 5'd5,  1, DATA_MEM_wbmux, 32'hDEADBEEF, 1, 4'b1111, 32'h0,        0);
    run(1, 0, BYTE_size, 0, 32'h00000103, 32'h0,        32'h80FF0000, 0, 5'd6,  1, DATA_MEM_wbmux, 32'hFFFFFF80, 1, 4'b1111, 32'h0,        0);
    run(1, 0, BYTE_size, 1, 32'h00000103, 32'h0,        32'h80FF0000, 0, 5'd7,  1, DATA_MEM_wbmux, 32'h00000080, 1, 4'b1111, 32'h0,        0);
    run(1, 0, HALF_size, 0, 32'h00000102, 32'h0,        32'h80FF0000, 0, 5'd8,  1, DATA_MEM_wbmux, 32'hFFFF80FF, 1, 4'b1111, 32'h0,        0);
    run(1, 0, HALF_size, 1, 32'h00000100, 32'h0,        32'h1234F00F, 0, 5'd9,  1, DATA_MEM_wbmux, 32'h0000F00F, 1, 4'b1111, 32'h0,        0);
    run(1, 0, BYTE_size, 0, 32'h00000100, 32'h0,        32'h0000007F, 0, 5'd10, 1, DATA_MEM_wbmux, 32'h0000007F, 1, 4'b1111, 32'h0,        0);
    run(0, 1, BYTE_size, 0, 32'h00000201, 32'h12345678, 32'h0,        0, 5'd0,  0, ALU_wbmux,      32'h0,        1, 4'b0010, 32'h78787878, 0);
    run(0, 1, HALF_size, 0, 32'h00000202, 32'h12345678, 32'h0,        0, 5'd0,  0, ALU_wbmux,      32'h0,        1, 4'b1100, 32'h56785678, 0);
    run(0, 1, WORD_size, 0, 32'h00000204, 32'h12345678, 32'hFFFFFFFF, 0, 5'd0,  0, ALU_wbmux,      32'h0,        1, 4'b1111, 32'h12345678, 0);
    run(0, 0, WORD_size, 0, 32'h0000CAFE, 32'h0,        32'hFFFFFFFF, 0, 5'd11, 1, PC4_wbmux,      32'h0,        0, 4'b1111, 32'h0,        0);
    run(1, 0, WORD_size, 0, 32'h00000108, 32'h0,        32'h0BADF00D, 3, 5'd12, 1, DATA_MEM_wbmux, 32'h0BADF00D, 1, 4'b1111, 32'h0,        0);
    run(1, 0, WORD_size, 0, 32'h00000102, 32'h0,        32'hFFFFFFFF, 0, 5'd13, 1, DATA_MEM_wbmux, 32'h0,        0, 4'b1111, 32'h0,        1);
    run(0, 1, HALF_size, 0, 32'h00000101, 32'hAAAA5555, 32'h0,        0, 5'd0,  0, ALU_wbmux,      32'h0,        0, 4'b1111, 32'h0,        1);
    run(0, 1, WORD_size, 0, 32'h00000210, 32'hCAFEBABE, 32'h0,        2, 5'd0,  0, IMM_wbmux,      32'h0,        1, 4'b1111, 32'hCAFEBABE, 0);

    // Stranded request: reset while waiting, then a late acknowledge.
    @(negedge clk);
    EX_MEM_VALID       = 1'b1;
    EX_MEM_EXECUTE_OUT = 32'h00000300;
    EX_MEM_MEM_RD      = 1'b1;
    EX_MEM_MEM_WR      = 1'b0;
    EX_MEM_MEM_SIZE    = WORD_size;
    EX_MEM_WB_SRC_SEL  = DATA_MEM_wbmux;
    EX_MEM_RD          = 5'd14;
    EX_MEM_REG_WR      = 1'b1;
    DMEM_ACK           = 1'b0;
    #1;
    chk("rw_req", {31'd0, DMEM_REQ}, 32'd1);
    chk("rw_stall", {31'd0, MEM_STALL}, 32'd1);
    @(negedge clk);
    #1;
    chk("rw_wait_req", {31'd0, DMEM_REQ}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    clear_ex();
    #1;
    chk("rw_req_in_rst", {31'd0, DMEM_REQ}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    DMEM_ACK   = 1'b1;
    DMEM_RDATA = 32'hFFFFFFFF;
    #1;
    chk_wb_zero("rw_after_rst");
    chk("rw_stall_late_ack", {31'd0, MEM_STALL}, 32'd0);
    @(negedge clk);
    DMEM_ACK = 1'b0;
    #1;
    chk_wb_zero("rw_late_ack");

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
